// File: rtl/direct_mapped_refill_pkg.sv
// cache_pkg: shared definitions for the direct-mapped cache.
//   - Geometry constants: 16-bit byte address = {tag[3:0], index[7:0], word[1:0], byte[1:0]}.
//   - Line layout: {valid, tag, w0, w1, w2, w3}, 133 bits, w0 in the most significant word.
//   - cache_line_t: packed view of one line.
//   - state_t: refill/flush controller states.
// Used by both the refill controller and the combinational lookup path.
package cache_pkg;

    localparam int ADDR_W    = 16;
    localparam int TAG_W     = 4;
    localparam int INDEX_W   = 8;
    localparam int WORDS     = 4;
    localparam int DATA_W    = 32;
    localparam int WORD_SEL_W = 2;
    localparam int LINE_W    = 1 + TAG_W + WORDS * DATA_W;

    // Address field positions
    localparam int TAG_ADDR_LO   = ADDR_W - TAG_W;
    localparam int INDEX_ADDR_LO = TAG_ADDR_LO - INDEX_W;

    // Line layout bit positions
    localparam int VALID_BIT = 132;
    localparam int TAG_HI    = 131;
    localparam int TAG_LO    = 128;

    typedef struct packed {
        logic                          valid;
        logic [TAG_W-1:0]              tag;
        logic [0:WORDS-1][DATA_W-1:0]  word;
    } cache_line_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_RESP,
        ST_WRITE,
        ST_FLUSH
    } state_t;

endpackage

// File: rtl/direct_mapped_refill.sv
// direct_mapped_refill: refill and flush controller for the 256-line
// direct-mapped cache. Owns every write to the line store.
//   - On a miss, fetches the 4-word block in order (one outstanding request)
//     and writes {1, tag, w0..w3} in a single WRITE cycle.
//   - On flush, writes an all-zero line to every index, one per cycle.
// Ports:
//   clk_i, rst_i (async, active-low)
//   miss_valid_i / miss_addr_i / miss_ready_o : miss handshake from lookup
//   flush_i                                   : start invalidate sweep (idle only)
//   mem_req_o / mem_addr_o / mem_gnt_i        : memory read request
//   mem_rvalid_i / mem_rdata_i                : memory read response
//   line_we_o / line_index_o / line_data_o    : line store write port
//   done_o                                    : one-cycle completion pulse
// Every output is decoded from registered state only, so memory inputs never
// reach an output combinationally.
module direct_mapped_refill
    import cache_pkg::*;
(
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                miss_valid_i,
    input  logic [ADDR_W-1:0]   miss_addr_i,
    output logic                miss_ready_o,
    input  logic                flush_i,
    output logic                mem_req_o,
    output logic [ADDR_W-1:0]   mem_addr_o,
    input  logic                mem_gnt_i,
    input  logic                mem_rvalid_i,
    input  logic [DATA_W-1:0]   mem_rdata_i,
    output logic                line_we_o,
    output logic [INDEX_W-1:0]  line_index_o,
    output logic [LINE_W-1:0]   line_data_o,
    output logic                done_o
);

    state_t                  state_reg, state_next;
    logic [TAG_W-1:0]        tag_reg, tag_next;
    logic [INDEX_W-1:0]      index_reg, index_next;
    logic [WORD_SEL_W-1:0]   k_reg, k_next;
    logic [INDEX_W-1:0]      sweep_reg, sweep_next;
    logic [DATA_W-1:0]       word_reg [WORDS];
    logic [WORDS-1:0]        word_we;
    cache_line_t             fill_line;

    // Byte-offset bits of the miss address carry no information here.
    logic unused_offset;
    assign unused_offset = ^miss_addr_i[INDEX_ADDR_LO-1:0];

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_reg <= ST_IDLE;
            tag_reg   <= '0;
            index_reg <= '0;
            k_reg     <= '0;
            sweep_reg <= '0;
        end else begin
            state_reg <= state_next;
            tag_reg   <= tag_next;
            index_reg <= index_next;
            k_reg     <= k_next;
            sweep_reg <= sweep_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        tag_next   = tag_reg;
        index_next = index_reg;
        k_next     = k_reg;
        sweep_next = sweep_reg;
        case (state_reg)
            ST_IDLE: begin
                // Flush wins; a simultaneous miss stays pending at the requester.
                if (flush_i) begin
                    sweep_next = '0;
                    state_next = ST_FLUSH;
                end else if (miss_valid_i) begin
                    tag_next   = miss_addr_i[ADDR_W-1:TAG_ADDR_LO];
                    index_next = miss_addr_i[TAG_ADDR_LO-1:INDEX_ADDR_LO];
                    k_next     = '0;
                    state_next = ST_REQ;
                end
            end
            ST_REQ: begin
                if (mem_gnt_i) state_next = ST_RESP;
            end
            ST_RESP: begin
                if (mem_rvalid_i) begin
                    if (k_reg == WORD_SEL_W'(WORDS - 1)) begin
                        state_next = ST_WRITE;
                    end else begin
                        k_next     = k_reg + 1'b1;
                        state_next = ST_REQ;
                    end
                end
            end
            ST_WRITE: begin
                state_next = ST_IDLE;
            end
            ST_FLUSH: begin
                if (sweep_reg == '1) state_next = ST_IDLE;
                else                 sweep_next = sweep_reg + 1'b1;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Word buffer: one register per word, loaded when its response arrives.
    generate
        for (genvar gi = 0; gi < WORDS; gi++) begin : g_word
            assign word_we[gi] = (state_reg == ST_RESP) && mem_rvalid_i &&
                                 (k_reg == WORD_SEL_W'(gi));

            always_ff @(posedge clk_i or negedge rst_i) begin
                if (!rst_i)           word_reg[gi] <= '0;
                else if (word_we[gi]) word_reg[gi] <= mem_rdata_i;
            end

            assign fill_line.word[gi] = word_reg[gi];
        end
    endgenerate

    assign fill_line.valid = 1'b1;
    assign fill_line.tag   = tag_reg;

    assign miss_ready_o = (state_reg == ST_IDLE);
    assign mem_req_o    = (state_reg == ST_REQ);
    assign mem_addr_o   = (state_reg == ST_REQ) ?
                          {tag_reg, index_reg, k_reg, 2'b00} : '0;

    always_comb begin
        line_we_o    = 1'b0;
        line_index_o = '0;
        line_data_o  = '0;
        done_o       = 1'b0;
        case (state_reg)
            ST_WRITE: begin
                line_we_o    = 1'b1;
                line_index_o = index_reg;
                line_data_o  = fill_line;
                done_o       = 1'b1;
            end
            ST_FLUSH: begin
                // Flush lines are all-zero, so line_data_o keeps its default.
                line_we_o    = 1'b1;
                line_index_o = sweep_reg;
                done_o       = (sweep_reg == '1);
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_direct_mapped_refill.sv
module tb_direct_mapped_refill;

    logic          clk_i;
    logic          rst_i;
    logic          miss_valid_i;
    logic [15:0]   miss_addr_i;
    logic          miss_ready_o;
    logic          flush_i;
    logic          mem_req_o;
    logic [15:0]   mem_addr_o;
    logic          mem_gnt_i;
    logic          mem_rvalid_i;
    logic [31:0]   mem_rdata_i;
    logic          line_we_o;
    logic [7:0]    line_index_o;
    logic [132:0]  line_data_o;
    logic          done_o;

    direct_mapped_refill dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .miss_valid_i (miss_valid_i),
        .miss_addr_i  (miss_addr_i),
        .miss_ready_o (miss_ready_o),
        .flush_i      (flush_i),
        .mem_req_o    (mem_req_o),
        .mem_addr_o   (mem_addr_o),
        .mem_gnt_i    (mem_gnt_i),
        .mem_rvalid_i (mem_rvalid_i),
        .mem_rdata_i  (mem_rdata_i),
        .line_we_o    (line_we_o),
        .line_index_o (line_index_o),
        .line_data_o  (line_data_o),
        .done_o       (done_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    int n_cmp = 0;
    int n_err = 0;

    // Reference line store (expected) and observed line store (from DUT writes).
    logic [132:0] model_store [256];
    logic [132:0] dut_store   [256];

    always @(posedge clk_i) begin
        if (rst_i && line_we_o) dut_store[line_index_o] <= line_data_o;
    end

    typedef struct {
        logic [15:0]         addr;
        logic [0:3][31:0]    d;
        logic [0:3][3:0]     gd;
        logic [0:3][3:0]     rd;
        bit                  noise;
        logic [7:0]          exp_index;
        logic [132:0]        exp_line;
        int                  exp_cyc;
    } vec_t;

    vec_t vecs [3];

    task automatic chk(input string name, input logic [132:0] act, input logic [132:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, " miss_ready"}, miss_ready_o, 1);
        chk({tag, " mem_req"},    mem_req_o,    0);
        chk({tag, " mem_addr"},   mem_addr_o,   0);
        chk({tag, " line_we"},    line_we_o,    0);
        chk({tag, " line_index"}, line_index_o, 0);
        chk({tag, " line_data"},  line_data_o,  0);
        chk({tag, " done"},       done_o,       0);
    endtask

    // Acts as requester and backing memory for one refill. Called at a
    // negedge with the controller idle. abort_k >= 0 returns once word
    // abort_k has been granted, leaving the controller in RESP.
    task automatic refill(input logic [15:0] addr, input logic [0:3][31:0] d,
                          input logic [0:3][3:0] gd, input logic [0:3][3:0] rd,
                          input bit noise, input int abort_k,
                          input logic [7:0] exp_index, input logic [132:0] exp_line,
                          input int exp_cyc);
        int cyc;
        logic [15:0] ea;
        miss_valid_i = 1'b1;
        miss_addr_i  = addr;
        chk("accept miss_ready", miss_ready_o, 1);
        @(negedge clk_i);
        miss_valid_i = 1'b0;
        miss_addr_i  = 16'($urandom);
        cyc = 1;
        for (int k = 0; k < 4; k++) begin
            ea = {addr[15:4], 2'(k), 2'b00};
            for (int w = 0; w <= int'(gd[k]); w++) begin
                chk("req mem_req", mem_req_o, 1);
                chk("req mem_addr", mem_addr_o, ea);
                chk("req line_we", line_we_o, 0);
                mem_gnt_i    = (w == int'(gd[k]));
                mem_rvalid_i = noise;
                mem_rdata_i  = $urandom;
                @(negedge clk_i);
                cyc++;
            end
            mem_gnt_i    = 1'b0;
            mem_rvalid_i = 1'b0;
            if (k == abort_k) return;
            for (int w = 0; w <= int'(rd[k]); w++) begin
                chk("resp mem_req", mem_req_o, 0);
                chk("resp done", done_o, 0);
                mem_rvalid_i = (w == int'(rd[k]));
                mem_rdata_i  = (w == int'(rd[k])) ? d[k] : $urandom;
                mem_gnt_i    = noise;
                @(negedge clk_i);
                cyc++;
            end
            mem_gnt_i    = 1'b0;
            mem_rvalid_i = 1'b0;
        end
        chk("write line_we", line_we_o, 1);
        chk("write line_index", line_index_o, exp_index);
        chk("write line_data", line_data_o, exp_line);
        chk("write done", done_o, 1);
        chk("write miss_ready", miss_ready_o, 0);
        chk("write cycle", 133'(cyc), 133'(exp_cyc));
        model_store[exp_index] = exp_line;
        $display("txn refill addr=%h index=%h cycles=%0d line=%h", addr, line_index_o, cyc, line_data_o);
        @(negedge clk_i);
        chk("post done", done_o, 0);
        chk("post line_we", line_we_o, 0);
        chk("post line_data", line_data_o, 0);
        chk("post miss_ready", miss_ready_o, 1);
    endtask

    initial begin
        logic [15:0]      ra;
        logic [0:3][31:0] rdat;
        logic [0:3][3:0]  rgd, rrd;
        int               rsum;
        int               store_bad;

        for (int i = 0; i < 256; i++) begin
            model_store[i] = '0;
            dut_store[i]   = '0;
        end

        vecs[0] = '{16'h3A5C, {32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444},
                    {4'd0, 4'd0, 4'd0, 4'd0}, {4'd0, 4'd0, 4'd0, 4'd0}, 1'b0, 8'hA5,
                    133'h13_11111111_22222222_33333333_44444444, 9};
        vecs[1] = '{16'h3A5C, {32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444},
                    {4'd0, 4'd3, 4'd0, 4'd0}, {4'd0, 4'd2, 4'd0, 4'd0}, 1'b1, 8'hA5,
                    133'h13_11111111_22222222_33333333_44444444, 14};
        vecs[2] = '{16'hFFFF, {32'hDEADBEEF, 32'h01234567, 32'h89ABCDEF, 32'h0F0F0F0F},
                    {4'd1, 4'd0, 4'd2, 4'd0}, {4'd0, 4'd3, 4'd0, 4'd1}, 1'b1, 8'hFF,
                    133'h1F_DEADBEEF_01234567_89ABCDEF_0F0F0F0F, 16};

        // Reset held with a pending miss: nothing may be requested.
        rst_i        = 1'b0;
        miss_valid_i = 1'b1;
        miss_addr_i  = 16'h3A5C;
        flush_i      = 1'b0;
        mem_gnt_i    = 1'b0;
        mem_rvalid_i = 1'b0;
        mem_rdata_i  = '0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            chk_reset_outputs("in_reset");
        end
        miss_valid_i = 1'b0;
        rst_i        = 1'b1;
        @(negedge clk_i);
        chk_reset_outputs("after_reset");
        $display("txn reset release miss_ready=%b", miss_ready_o);

        // Directed table.
        for (int v = 0; v < 3; v++) begin
            refill(vecs[v].addr, vecs[v].d, vecs[v].gd, vecs[v].rd, vecs[v].noise, -1,
                   vecs[v].exp_index, vecs[v].exp_line, vecs[v].exp_cyc);
        end

        // Flush and miss together: flush first, miss accepted afterwards.
        flush_i      = 1'b1;
        miss_valid_i = 1'b1;
        miss_addr_i  = 16'h0ABC;
        @(negedge clk_i);
        flush_i = 1'b0;
        for (int i = 0; i < 256; i++) begin
            chk("flush line_we", line_we_o, 1);
            chk("flush line_index", line_index_o, 133'(i));
            chk("flush line_data", line_data_o, 0);
            chk("flush done", done_o, 133'(i == 255));
            chk("flush miss_ready", miss_ready_o, 0);
            @(negedge clk_i);
        end
        for (int i = 0; i < 256; i++) model_store[i] = '0;
        $display("txn flush 256 lines");
        rdat = {32'hA0A0A0A0, 32'hB1B1B1B1, 32'hC2C2C2C2, 32'hD3D3D3D3};
        refill(16'h0ABC, rdat, '0, '0, 1'b0, -1, 8'hAB, {1'b1, 4'h0, rdat}, 9);

        // Reset while waiting for word 3: no write, no done, clean restart.
        rdat = {32'h55555555, 32'h66666666, 32'h77777777, 32'h88888888};
        refill(16'h5678, rdat, '0, '0, 1'b0, 3, 8'h67, '0, 0);
        chk("abort in resp mem_req", mem_req_o, 0);
        rst_i = 1'b0;
        #1;
        chk_reset_outputs("abort_reset");
        @(negedge clk_i);
        chk_reset_outputs("abort_hold");
        rst_i = 1'b1;
        @(negedge clk_i);
        chk_reset_outputs("abort_release");
        $display("txn abort refill addr=5678");
        rdat = {32'hCAFEF00D, 32'h12345678, 32'h9ABCDEF0, 32'h0BADC0DE};
        refill(16'h1234, rdat, '0, '0, 1'b0, -1, 8'h23, {1'b1, 4'h1, rdat}, 9);

        // Random refills against the reference: line = {1, tag, w0..w3},
        // latency = 9 + every extra grant and rvalid wait cycle.
        for (int n = 0; n < 20; n++) begin
            ra   = 16'($urandom);
            rsum = 9;
            for (int k = 0; k < 4; k++) begin
                rdat[k] = $urandom;
                rgd[k]  = 4'($urandom_range(0, 3));
                rrd[k]  = 4'($urandom_range(0, 3));
                rsum    = rsum + int'(rgd[k]) + int'(rrd[k]);
            end
            refill(ra, rdat, rgd, rrd, bit'($urandom_range(0, 1)), -1,
                   ra[11:4], {1'b1, ra[15:12], rdat}, rsum);
        end

        // Every write the DUT made must match the reference line store.
        @(negedge clk_i);
        store_bad = 0;
        for (int i = 0; i < 256; i++) begin
            if (dut_store[i] !== model_store[i]) store_bad++;
        end
        chk("line store contents", 133'(store_bad), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
